logic_unit_arbiter: RTL

//  Shares one 8-bit logic unit (OR/AND/XOR/NOT datapath, 2-bit select) between two requesters.

---
 rtl/logic_unit_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester front end for a shared combinational logic unit (OR/AND/XOR/NOT).
// Grants one request at a time, drives the unit for one cycle, and returns a tagged response.
module logic_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] lu_x,
  output logic [WIDTH-1:0] lu_y,
  output logic             lu_sel1,
  output logic             lu_sel0,
  input  logic [WIDTH-1:0] lu_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_id;
  logic   id_q;
  logic   gnt0, gnt1;

  // On a tie req0 wins unless it was the last one served (round-robin) or always (fixed).
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | (RR_EN == 1'b0) | last_id);
    gnt1 = req1_valid & ~gnt0;
  end

  assign req0_ready = (state == IDLE) & gnt0;
  assign req1_ready = (state == IDLE) & gnt1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      id_q      <= 1'b0;
      lu_x      <= '0;
      lu_y      <= '0;
      lu_sel1   <= 1'b0;
      lu_sel0   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            lu_x    <= gnt1 ? req1_x : req0_x;
            lu_y    <= gnt1 ? req1_y : req0_y;
            lu_sel1 <= gnt1 ? req1_op[1] : req0_op[1];
            lu_sel0 <= gnt1 ? req1_op[0] : req0_op[0];
            id_q    <= gnt1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= lu_f;
          rsp_id    <= id_q;
          rsp_zero  <= (lu_f == '0);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last_id   <= rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
